// File: rtl/eq_serial_ctrl_amisha_pkg.sv
// Shared definitions for the serial equality sequencer.
// Holds the sequencer state encoding and the clog2 helper used to size the
// bit index and mismatch index.
package eq_serial_ctrl_amisha_pkg;

  // Encoding 2'd3 is unused; the sequencer treats it as a fault and
  // falls back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing. Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/eq_serial_ctrl_amisha_eq1.sv
// One-bit equality cell, the shared comparison resource of the serial
// comparator. Purely combinational.
// Ports:
//   a_bit, b_bit : input bits to compare
//   eq_bit       : 1 when a_bit equals b_bit
module eq1_implicit_amisha (
  input  logic a_bit,
  input  logic b_bit,
  output logic eq_bit
);

  assign eq_bit = ~(a_bit ^ b_bit);

endmodule

// File: rtl/eq_serial_ctrl_amisha.sv
// Serial equality comparator: time-shares a single 1-bit equality cell to
// compare two WIDTH-bit words LSB first, stopping at the first differing bit.
// Ports:
//   clk_amisha          : clock, rising edge
//   reset_amisha        : asynchronous active-high reset
//   start_amisha        : request pulse, only honoured while idle
//   a_amisha, b_amisha  : operands, captured when a request is accepted
//   busy_amisha         : high from the cycle after acceptance through done
//   done_amisha         : one-cycle pulse when eq/mismatch_idx are valid
//   eq_amisha           : 1 when the operands were equal; held until next start
//   mismatch_idx_amisha : index of the first differing bit, 0 when equal
module eq_serial_ctrl_amisha
  import eq_serial_ctrl_amisha_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             eq_amisha,
  output logic [IDX_W-1:0] mismatch_idx_amisha
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDX_W-1:0] idx;
  logic             bit_eq;

  // The single shared comparison cell always looks at the current LSBs of
  // the operand shift registers.
  eq1_implicit_amisha u_eq1 (
    .a_bit  (sa[0]),
    .b_bit  (sb[0]),
    .eq_bit (bit_eq)
  );

  // Sequencer. All outputs are registered here so nothing combinational
  // reaches a port. The operands are copied on acceptance, which is why the
  // inputs may change freely while the compare runs. In RUN the index is
  // only advanced when it is below the last bit, so it cannot wrap.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state               <= ST_IDLE;
      sa                  <= '0;
      sb                  <= '0;
      idx                 <= '0;
      busy_amisha         <= 1'b0;
      done_amisha         <= 1'b0;
      eq_amisha           <= 1'b0;
      mismatch_idx_amisha <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_amisha <= 1'b0;
          if (start_amisha) begin
            sa                  <= a_amisha;
            sb                  <= b_amisha;
            idx                 <= '0;
            eq_amisha           <= 1'b0;
            mismatch_idx_amisha <= '0;
            busy_amisha         <= 1'b1;
            state               <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!bit_eq) begin
            eq_amisha           <= 1'b0;
            mismatch_idx_amisha <= idx;
            done_amisha         <= 1'b1;
            state               <= ST_DONE;
          end else if (idx == LAST_IDX) begin
            eq_amisha           <= 1'b1;
            mismatch_idx_amisha <= '0;
            done_amisha         <= 1'b1;
            state               <= ST_DONE;
          end else begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            idx <= idx + IDX_W'(1);
          end
        end

        ST_DONE: begin
          done_amisha <= 1'b0;
          busy_amisha <= 1'b0;
          state       <= ST_IDLE;
        end

        default: begin
          done_amisha <= 1'b0;
          busy_amisha <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_serial_ctrl_amisha.sv
// Directed testbench for eq_serial_ctrl_amisha at WIDTH=8.
// Cycle numbering: the request is driven in cycle 0 and accepted on the
// rising edge that ends it; cycle n is the period after n such edges.
// Inputs are driven and outputs sampled on the falling edge.
module tb_eq_serial_ctrl_amisha;

  logic       clk_amisha;
  logic       reset_amisha;
  logic       start_amisha;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy_out;
  logic       done_out;
  logic       eq_out;
  logic [2:0] idx_out;

  int total_checks;
  int bad_checks;

  eq_serial_ctrl_amisha #(.WIDTH(8)) dut (
    .clk_amisha          (clk_amisha),
    .reset_amisha        (reset_amisha),
    .start_amisha        (start_amisha),
    .a_amisha            (a_in),
    .b_amisha            (b_in),
    .busy_amisha         (busy_out),
    .done_amisha         (done_out),
    .eq_amisha           (eq_out),
    .mismatch_idx_amisha (idx_out)
  );

  // 10 ns clock
  initial begin
    clk_amisha = 1'b0;
    forever #5 clk_amisha = ~clk_amisha;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a one-cycle request at the current falling edge (cycle 0) and
  // return at the falling edge of cycle 1
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    a_in         = a;
    b_in         = b;
    start_amisha = 1'b1;
    @(negedge clk_amisha);
    start_amisha = 1'b0;
  endtask

  // Run one compare and check busy/eq during the run, the done cycle and
  // the result. Returns at the falling edge of the done cycle.
  task automatic runCompare(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input int exp_done,
                            input logic exp_eq, input int exp_idx,
                            input bit scramble);
    int done_cyc;
    done_cyc = 0;
    applyStimulus(a, b);
    for (int c = 1; c <= 40; c++) begin
      if (scramble) begin
        a_in = 8'(c * 37);
        b_in = a_in ^ 8'h5A;
      end
      checkOutput({tag, "_busy"}, 32'(busy_out), 32'd1);
      if (done_out) begin
        done_cyc = c;
        break;
      end
      checkOutput({tag, "_eq_run"}, 32'(eq_out), 32'd0);
      @(negedge clk_amisha);
    end
    checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    checkOutput({tag, "_eq"}, 32'(eq_out), 32'(exp_eq));
    checkOutput({tag, "_idx"}, 32'(idx_out), 32'(exp_idx));
  endtask

  // Move to the cycle after done and confirm the block is idle again
  task automatic checkIdleAfter(input string tag);
    @(negedge clk_amisha);
    checkOutput({tag, "_post_done"}, 32'(done_out), 32'd0);
    checkOutput({tag, "_post_busy"}, 32'(busy_out), 32'd0);
  endtask

  int done_count;

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    reset_amisha = 1'b1;
    start_amisha = 1'b0;
    a_in         = 8'h00;
    b_in         = 8'h00;
    repeat (3) @(negedge clk_amisha);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_done", 32'(done_out), 32'd0);
    checkOutput("rst_eq", 32'(eq_out), 32'd0);
    checkOutput("rst_idx", 32'(idx_out), 32'd0);
    reset_amisha = 1'b0;
    @(negedge clk_amisha);

    // 1: equal operands, full-length run
    runCompare("s1", 8'hA5, 8'hA5, 9, 1'b1, 0, 1'b0);
    checkIdleAfter("s1");

    // 2: mismatch at bit 0, then at bit 7
    runCompare("s2a", 8'hA5, 8'hA4, 2, 1'b0, 0, 1'b0);
    checkIdleAfter("s2a");
    runCompare("s2b", 8'h00, 8'h80, 9, 1'b0, 7, 1'b0);
    checkIdleAfter("s2b");

    // 3: start held for cycles 0..11; only one compare until done,
    // retrigger accepted in the cycle after done (cycle 7)
    a_in         = 8'h0F;
    b_in         = 8'h1F;
    start_amisha = 1'b1;
    done_count   = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk_amisha);
      if (c == 12) start_amisha = 1'b0;
      if (c <= 12 && done_out) done_count++;
      if (c == 6) begin
        checkOutput("s3_done6", 32'(done_out), 32'd1);
        checkOutput("s3_eq", 32'(eq_out), 32'd0);
        checkOutput("s3_idx", 32'(idx_out), 32'd4);
      end
      if (c == 7) checkOutput("s3_busy7", 32'(busy_out), 32'd0);
      if (c == 8) begin
        checkOutput("s3_busy8", 32'(busy_out), 32'd1);
        checkOutput("s3_eq_cleared", 32'(eq_out), 32'd0);
      end
      if (c == 13) checkOutput("s3_second_done", 32'(done_out), 32'd1);
    end
    checkOutput("s3_done_count", 32'(done_count), 32'd1);
    checkIdleAfter("s3");

    // 4: asynchronous reset in the middle of a run
    applyStimulus(8'hFF, 8'hFF);
    repeat (3) @(negedge clk_amisha);
    checkOutput("s4_busy_pre", 32'(busy_out), 32'd1);
    #2;
    reset_amisha = 1'b1;
    #1;
    checkOutput("s4_busy_rst", 32'(busy_out), 32'd0);
    checkOutput("s4_done_rst", 32'(done_out), 32'd0);
    checkOutput("s4_eq_rst", 32'(eq_out), 32'd0);
    checkOutput("s4_idx_rst", 32'(idx_out), 32'd0);
    @(negedge clk_amisha);
    @(negedge clk_amisha);
    reset_amisha = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_amisha);
      checkOutput("s4_no_done", 32'(done_out), 32'd0);
      checkOutput("s4_no_busy", 32'(busy_out), 32'd0);
    end
    runCompare("s4", 8'hA5, 8'hA5, 9, 1'b1, 0, 1'b0);
    checkIdleAfter("s4");

    // 5: operand inputs scrambled during the run; result then held
    runCompare("s5", 8'h3C, 8'h3C, 9, 1'b1, 0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_amisha);
      checkOutput("s5_eq_hold", 32'(eq_out), 32'd1);
    end

    // 6: a new start clears eq, then back-to-back restart right after done
    runCompare("s6a", 8'h01, 8'h03, 3, 1'b0, 1, 1'b0);
    checkIdleAfter("s6a");
    runCompare("s6b", 8'h01, 8'h03, 3, 1'b0, 1, 1'b0);
    checkIdleAfter("s6b");

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  // Guard against a hung simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
